picorv32_mem_arbiter: RTL

Two-requester arbiter sharing one picorv32 native memory port (valid/ready/addr/wdata/wstrb/rdata) between two masters, e.g. two cores or a core plus a DMA/debug port. Sits between the requesters and the single memory model or bus bridge. Grants one transfer at a time, round-robin or fixed priority, and flags a sticky error when the downstream port stalls too long.

---
 rtl/picorv32_mem_arb_pkg.sv | 26 ++
 rtl/picorv32_mem_if.sv | 24 ++
 rtl/picorv32_mem_arb_watchdog.sv | 33 +++
 rtl/picorv32_mem_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/picorv32_mem_arb_pkg.sv
// Shared types and constants for the two-requester picorv32 memory arbiter.
// Holds the FSM encoding, requester indices and the request bundle layout.
package picorv32_mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

endpackage

// File: rtl/picorv32_mem_if.sv
// picorv32 native memory port; master drives the request, slave answers.
// No storage: ready/rdata return in the same cycle the slave accepts.
interface picorv32_mem_if;
  import picorv32_mem_arb_pkg::*;

  logic              mem_valid;
  logic              mem_instr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/picorv32_mem_arb_watchdog.sv
// Stall watchdog: saturating 16-bit stall counter plus sticky error flag.
// Latency: err rises one edge after the limit-th stalled cycle; never blocks traffic.
module picorv32_mem_arb_watchdog (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        clear,
  input  logic [15:0] limit,
  output logic        err
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= 16'd0;
    end else if (clear) begin
      cnt <= 16'd0;
    end else if (stall && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  // A zero limit disables the flag; only reset clears it once set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (limit != 16'd0 && stall && cnt == limit - 16'd1) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Two-requester arbiter onto one picorv32 memory port, round-robin or fixed priority.
// Latency: grant one edge after valid in IDLE; ready/rdata pass through combinationally.
module picorv32_mem_arbiter
  import picorv32_mem_arb_pkg::*;
#(
  parameter bit          PRIORITY_FIXED = 1'b0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd0
) (
  input  logic                   clk,
  input  logic                   resetn,
  picorv32_mem_if.slave          s0,
  picorv32_mem_if.slave          s1,
  picorv32_mem_if.master         m,
  output logic [1:0]             grant,
  output logic                   timeout_err
);

  state_t state;
  state_t state_nxt;
  logic   last_served;
  req_t   req0;
  req_t   req1;
  req_t   m_req;
  logic   done;
  logic   stall;
  logic   abandon;
  logic   wd_clear;

  assign req0 = {s0.mem_valid, s0.mem_instr, s0.mem_addr, s0.mem_wdata, s0.mem_wstrb};
  assign req1 = {s1.mem_valid, s1.mem_instr, s1.mem_addr, s1.mem_wdata, s1.mem_wstrb};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Reset value REQ1 lets requester 0 win the first round-robin tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_served <= REQ1;
    end else if (done) begin
      last_served <= (state == BUSY1) ? REQ1 : REQ0;
    end
  end

  // On a completion edge the owner's valid is still high, so handover
  // looks only at the other requester and never re-grants the owner.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0.valid && req1.valid) begin
          state_nxt = (PRIORITY_FIXED || last_served == REQ1) ? BUSY0 : BUSY1;
        end else if (req0.valid) begin
          state_nxt = BUSY0;
        end else if (req1.valid) begin
          state_nxt = BUSY1;
        end
      end
      BUSY0: begin
        if (done) begin
          state_nxt = req1.valid ? BUSY1 : IDLE;
        end else if (!req0.valid) begin
          state_nxt = IDLE;
        end
      end
      BUSY1: begin
        if (done) begin
          state_nxt = req0.valid ? BUSY0 : IDLE;
        end else if (!req1.valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_req = '0;
    case (state)
      BUSY0:   m_req = req0;
      BUSY1:   m_req = req1;
      default: m_req = '0;
    endcase
    grant = {state == BUSY1, state == BUSY0};
  end

  assign m.mem_valid = m_req.valid;
  assign m.mem_instr = m_req.instr;
  assign m.mem_addr  = m_req.addr;
  assign m.mem_wdata = m_req.wdata;
  assign m.mem_wstrb = m_req.wstrb;

  assign done    = m_req.valid & m.mem_ready;
  assign stall   = m_req.valid & ~m.mem_ready;
  assign abandon = (state != IDLE) & ~m_req.valid;

  assign s0.mem_ready = (state == BUSY0) & done;
  assign s1.mem_ready = (state == BUSY1) & done;
  assign s0.mem_rdata = m.mem_rdata;
  assign s1.mem_rdata = m.mem_rdata;

  assign wd_clear = (state == IDLE) | done | abandon;

  picorv32_mem_arb_watchdog u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .stall  (stall),
    .clear  (wd_clear),
    .limit  (TIMEOUT_CYCLES),
    .err    (timeout_err)
  );

endmodule
